address_window_map: RTL
=======================

// Module: address_window_map
// PURPOSE
//  Table-driven successor to the fixed-mapper address decoder. It holds NUM_WIN
//  programmable match windows, replacing the hard-coded HiROM/LoROM/BS-X equations.
//  The MCU loads the windows over a shadow/commit config port. Each SNES address is
//  translated through a 2-stage pipeline into ROM_ADDR plus hit/saveram/writable
//  qualifiers. It sits between the SNES address capture logic and the SRAM arbiter.
// PARAMETERS
//  NUM_WIN   8   number of match windows (1..16); lowest index has highest priority
//  ADDR_W    24  SNES/SRAM address width
//  IDX_W     4   width of cfg_idx and hit_idx; must satisfy 2**IDX_W >= NUM_WIN
// PORTS
//  CLK              in   1       system clock
//  RST              in   1       synchronous, active-high reset
//  cfg_we           in   1       write cfg_data into shadow[cfg_idx].field[cfg_field]
//  cfg_idx          in   IDX_W   window index
//  cfg_field        in   3       0=match_val 1=match_mask 2=dest_base 3=dest_mask 4=flags
//  cfg_data         in   ADDR_W  field data; flags use bits [3:0]
//  cfg_commit       in   1       copy all shadow windows to the active table
//  addr_valid       in   1       SNES_ADDR_early/SNES_WRITE_early are valid this cycle
//  SNES_ADDR_early  in   ADDR_W  address to translate
//  SNES_WRITE_early in   1       low = write cycle
//  out_valid        out  1       outputs below are valid this cycle
//  ROM_ADDR         out  ADDR_W  translated SRAM address
//  ROM_HIT          out  1       some enabled window matched
//  IS_SAVERAM       out  1       matched window has the SAVERAM flag set
//  IS_WRITABLE      out  1       matched window has the WRITABLE flag set
//  hit_idx          out  IDX_W   index of the matching window
// BEHAVIOUR
//  - Flags: [0]=EN [1]=SAVERAM [2]=WRITABLE [3]=LOFOLD.
//  - Window w matches when EN=1 and (A & match_mask) == match_val, where A is the
//    address captured in stage 1.
//  - Source address:
//      LOFOLD=1: src = {1'b0, A[23:16], A[14:0]}
//      LOFOLD=0: src = A
//  - ROM_ADDR = dest_base + (src & dest_mask), computed modulo 2**ADDR_W (carry dropped).
//  - Priority: when several windows match, the lowest index wins. Outputs reflect that
//    window only.
//  - Miss: ROM_HIT=0, IS_SAVERAM=0, IS_WRITABLE=0, ROM_ADDR=0, hit_idx=0.
//    out_valid still asserts on a miss.
//  - Pipeline:
//      Stage 1 registers A, the write flag and the per-window hit vector.
//      Stage 2 priority-encodes the hit vector, adds, and registers all outputs.
//      out_valid = addr_valid delayed exactly 2 cycles. Full throughput: 1 lookup/cycle.
//    When out_valid=0, the data outputs hold their previous value.
//  - WRITABLE with write cycles: a write (SNES_WRITE_early=0) to a window without
//    WRITABLE still reports ROM_HIT=1 and IS_WRITABLE=0. Blocking the write is the
//    arbiter's job.
//  - Config writes:
//    - cfg_we writes only the shadow table, one cycle to take effect.
//    - cfg_idx >= NUM_WIN and cfg_field > 4 are silently ignored.
//  - Commit:
//    - cfg_commit copies the whole shadow table to the active table at the clock edge.
//    - Lookups whose stage 1 occurs on the cycle after commit, or later, use the new
//      table. Lookups already in stage 1/2 finish with the old table.
//    - The active table is never partially updated.
//  - cfg_we and cfg_commit in the same cycle: the write lands in shadow AND is
//    included in the commit.
//  - Reset:
//    - All shadow and active fields are 0, so every window is disabled.
//    - The pipeline is flushed: out_valid=0 on the cycle after RST and on the next
//      one. Lookups in flight at reset are dropped.
//    - All outputs are 0.
//  - Reset mid-config: shadow content is lost and the MCU must reload it.
// TESTING
//  1. Reset: after RST, addr_valid with any address -> 2 cycles later out_valid=1,
//     ROM_HIT=0, ROM_ADDR=0.
//  2. HiROM window:
//     - w0 {val=C00000, mask=C00000, base=0, dmask=3FFFFF, flags=1}, commit.
//     - Addr C12345 -> ROM_ADDR=012345, hit_idx=0, out_valid exactly 2 cycles after
//       addr_valid.
//  3. LoROM fold plus saveram priority:
//     - w0 {val=700000, mask=F08000, base=E00000, dmask=07FFFF, flags=7}.
//     - w1 {val=008000, mask=008000, base=0, dmask=3FFFFF, flags=9}.
//     - Addr 701234 -> ROM_ADDR=E01234, IS_SAVERAM=1, IS_WRITABLE=1, hit_idx=0.
//     - Addr 018000 -> ROM_ADDR=000000 + (src=008000 & dmask) = 008000, hit_idx=1.
//  4. Atomic commit: with back-to-back lookups streaming, rewrite w0.dest_base=100000
//     with no commit -> outputs unchanged. Then commit -> the first lookup in stage 1
//     after the commit edge shows the +100000 offset; earlier ones do not.
//  5. Boundaries:
//     - Write with cfg_idx=NUM_WIN -> no window changes.
//     - dest_base=FFFFFF, src=000002 -> ROM_ADDR=000001 (wrap).
//     - cfg_we and cfg_commit in the same cycle -> the new value is active.
//  6. Reset mid-stream: assert RST while 2 lookups are in flight -> out_valid=0 for
//     both, and every window reads as disabled afterwards.

Source files
------------

// File: rtl/address_window_map.sv
// Table-driven SNES address decoder: NUM_WIN programmable windows loaded through a
// shadow/commit port, translating each address to ROM_ADDR over a 2-stage pipeline.
module address_window_map #(
  parameter int NUM_WIN = 8,
  parameter int ADDR_W  = 24,
  parameter int IDX_W   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [2:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_data,
  input  logic              cfg_commit,
  input  logic              addr_valid,
  input  logic [ADDR_W-1:0] SNES_ADDR_early,
  input  logic              SNES_WRITE_early,
  output logic              out_valid,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_HIT,
  output logic              IS_SAVERAM,
  output logic              IS_WRITABLE,
  output logic [IDX_W-1:0]  hit_idx
);

  localparam int FL_EN    = 0;
  localparam int FL_SAVE  = 1;
  localparam int FL_WR    = 2;
  localparam int FL_FOLD  = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] mval;
    logic [ADDR_W-1:0] mmask;
    logic [ADDR_W-1:0] dbase;
    logic [ADDR_W-1:0] dmask;
    logic [3:0]        flags;
  } win_t;

  win_t sh_q   [NUM_WIN];
  win_t sh_nxt [NUM_WIN];
  win_t act_q  [NUM_WIN];
  win_t act_p1 [NUM_WIN];

  logic [NUM_WIN-1:0] hit_s0;
  logic [NUM_WIN-1:0] hit_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic               wr_p1;
  logic               vld_p1;
  logic               unused_wr;

  logic               hit_any;
  logic [IDX_W-1:0]   idx_sel;
  win_t               win_sel;
  logic [ADDR_W-1:0]  rom_sum;

  // LoROM fold drops A15 and packs the bank byte directly above the 32 KiB offset.
  function automatic logic [ADDR_W-1:0] fold_src(input logic [ADDR_W-1:0] a,
                                                 input logic fold);
    return fold ? {1'b0, a[ADDR_W-1:16], a[14:0]} : a;
  endfunction

  always_comb begin
    for (int w = 0; w < NUM_WIN; w++) begin
      sh_nxt[w] = sh_q[w];
      if (cfg_we && cfg_idx == IDX_W'(w)) begin
        case (cfg_field)
          3'd0:    sh_nxt[w].mval  = cfg_data;
          3'd1:    sh_nxt[w].mmask = cfg_data;
          3'd2:    sh_nxt[w].dbase = cfg_data;
          3'd3:    sh_nxt[w].dmask = cfg_data;
          3'd4:    sh_nxt[w].flags = cfg_data[3:0];
          default: ;
        endcase
      end
    end
  end

  // act_p1 trails the active table by one cycle so a lookup finishes with the
  // table it was matched against, even across a commit edge.
  always_ff @(posedge CLK) begin
    for (int w = 0; w < NUM_WIN; w++) begin
      if (RST) begin
        sh_q[w]   <= '0;
        act_q[w]  <= '0;
        act_p1[w] <= '0;
      end else begin
        sh_q[w]   <= sh_nxt[w];
        act_p1[w] <= act_q[w];
        if (cfg_commit) act_q[w] <= sh_nxt[w];
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WIN; w++)
      hit_s0[w] = act_q[w].flags[FL_EN] &&
                  ((SNES_ADDR_early & act_q[w].mmask) == act_q[w].mval);
  end

  // ---- stage 1: capture address, write flag and per-window hit vector ----
  always_ff @(posedge CLK) begin
    if (RST) vld_p1 <= 1'b0;
    else     vld_p1 <= addr_valid;
  end

  always_ff @(posedge CLK) begin
    if (addr_valid) begin
      addr_p1 <= SNES_ADDR_early;
      wr_p1   <= SNES_WRITE_early;
      hit_p1  <= hit_s0;
    end
  end

  assign unused_wr = wr_p1;

  always_comb begin
    hit_any = 1'b0;
    idx_sel = '0;
    win_sel = '0;
    for (int w = NUM_WIN - 1; w >= 0; w--) begin
      if (hit_p1[w]) begin
        hit_any = 1'b1;
        idx_sel = IDX_W'(w);
        win_sel = act_p1[w];
      end
    end
    rom_sum = hit_any ? win_sel.dbase + (fold_src(addr_p1, win_sel.flags[FL_FOLD]) & win_sel.dmask)
                      : '0;
  end

  // ---- stage 2: priority-selected window drives the registered outputs ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid   <= 1'b0;
      ROM_ADDR    <= '0;
      ROM_HIT     <= 1'b0;
      IS_SAVERAM  <= 1'b0;
      IS_WRITABLE <= 1'b0;
      hit_idx     <= '0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        ROM_ADDR    <= rom_sum;
        ROM_HIT     <= hit_any;
        IS_SAVERAM  <= hit_any & win_sel.flags[FL_SAVE];
        IS_WRITABLE <= hit_any & win_sel.flags[FL_WR];
        hit_idx     <= idx_sel;
      end
    end
  end

endmodule
